// File: rtl/pwm_duty_capture_if.sv
// Measurement port of the PWM duty capture unit: the monitored pin in, captured values out.
// duty_valid is a one-cycle strobe with no back-pressure; the values it qualifies hold until the next strobe.
interface pwm_duty_capture_if #(
    parameter int CNT_W  = 16,
    parameter int DUTY_W = 8
);
    logic              pwm_in;
    logic [CNT_W-1:0]  high_cycles;
    logic [CNT_W-1:0]  period_cycles;
    logic [DUTY_W-1:0] duty;
    logic              duty_valid;
    logic              stuck;
    logic              overrun;
    logic [1:0]        dbg_state;

    modport master (
        output pwm_in,
        input  high_cycles, period_cycles, duty, duty_valid, stuck, overrun, dbg_state
    );

    modport slave (
        input  pwm_in,
        output high_cycles, period_cycles, duty, duty_valid, stuck, overrun, dbg_state
    );
endinterface

// File: rtl/pwm_duty_capture.sv
// Measures high time and period of a PWM pin, divides them into an 8-bit duty value,
// and reports a stuck line after a long stretch without edges.
module pwm_duty_capture #(
    parameter int CNT_W   = 16,
    parameter int DUTY_W  = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    pwm_duty_capture_if.slave bus
);
    localparam int IT_W = (DUTY_W > 1) ? $clog2(DUTY_W) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [IT_W-1:0]  IT_LAST   = IT_W'(DUTY_W - 1);

    typedef enum logic [1:0] {
        ST_DISARMED  = 2'd0,
        ST_WAIT_FALL = 2'd1,
        ST_WAIT_RISE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              sync3_q, sync3_d;
    logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0]  hi_cap_q, hi_cap_d;
    logic              div_busy_q, div_busy_d;
    logic [IT_W-1:0]   it_q, it_d;
    logic [CNT_W:0]    rem_q, rem_d;
    logic [DUTY_W-1:0] quo_q, quo_d;
    logic [CNT_W-1:0]  div_hi_q, div_hi_d;
    logic [CNT_W-1:0]  div_per_q, div_per_d;
    logic [CNT_W-1:0]  high_q, high_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              valid_q, valid_d;
    logic              stuck_q, stuck_d;
    logic              overrun_q, overrun_d;

    logic           rise, fall, timeout, q_bit;
    logic [CNT_W:0] rem_sh;

    assign rise    = sync2_q & ~sync3_q;
    assign fall    = ~sync2_q & sync3_q;
    assign timeout = (idle_cnt_q == TIMEOUT_C) && !stuck_q;
    assign rem_sh  = rem_q << 1;
    assign q_bit   = (rem_sh >= {1'b0, div_per_q});

    always_comb begin
        state_d    = state_q;
        sync1_d    = bus.pwm_in;
        sync2_d    = sync1_q;
        sync3_d    = sync2_q;
        hi_cap_d   = hi_cap_q;
        div_busy_d = div_busy_q;
        it_d       = it_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        div_hi_d   = div_hi_q;
        div_per_d  = div_per_q;
        high_d     = high_q;
        period_d   = period_q;
        duty_d     = duty_q;
        valid_d    = 1'b0;
        stuck_d    = stuck_q;
        overrun_d  = 1'b0;

        if (rise)                    per_cnt_d = CNT_W'(1);
        else if (per_cnt_q == CNT_MAX) per_cnt_d = per_cnt_q;
        else                         per_cnt_d = per_cnt_q + CNT_W'(1);

        if (rise || fall)                 idle_cnt_d = '0;
        else if (idle_cnt_q == TIMEOUT_C) idle_cnt_d = idle_cnt_q;
        else                              idle_cnt_d = idle_cnt_q + CNT_W'(1);

        // Restoring division, one quotient bit per cycle, MSB first.
        if (div_busy_q) begin
            rem_d = q_bit ? (rem_sh - {1'b0, div_per_q}) : rem_sh;
            quo_d = {quo_q[DUTY_W-2:0], q_bit};
            it_d  = it_q + IT_W'(1);
            if (it_q == IT_LAST) begin
                div_busy_d = 1'b0;
                valid_d    = 1'b1;
                high_d     = div_hi_q;
                period_d   = div_per_q;
                duty_d     = {quo_q[DUTY_W-2:0], q_bit};
                stuck_d    = 1'b0;
            end
        end

        case (state_q)
            ST_DISARMED: begin
                if (rise) state_d = ST_WAIT_FALL;
            end
            ST_WAIT_FALL: begin
                if (fall) begin
                    hi_cap_d = per_cnt_q;
                    state_d  = ST_WAIT_RISE;
                end
            end
            ST_WAIT_RISE: begin
                if (rise) begin
                    state_d = ST_WAIT_FALL;
                    if (!div_busy_q) begin
                        div_busy_d = 1'b1;
                        it_d       = '0;
                        rem_d      = {1'b0, hi_cap_q};
                        quo_d      = '0;
                        div_hi_d   = hi_cap_q;
                        div_per_d  = per_cnt_q;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_DISARMED;
        endcase

        // Timeout outranks any load, overrun or finishing division in the same cycle.
        if (timeout) begin
            state_d    = ST_DISARMED;
            div_busy_d = 1'b0;
            overrun_d  = 1'b0;
            valid_d    = 1'b1;
            duty_d     = sync2_q ? {DUTY_W{1'b1}} : '0;
            period_d   = '0;
            high_d     = sync2_q ? TIMEOUT_C : '0;
            stuck_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_DISARMED;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync3_q    <= 1'b0;
            per_cnt_q  <= '0;
            idle_cnt_q <= '0;
            hi_cap_q   <= '0;
            div_busy_q <= 1'b0;
            it_q       <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            div_hi_q   <= '0;
            div_per_q  <= '0;
            high_q     <= '0;
            period_q   <= '0;
            duty_q     <= '0;
            valid_q    <= 1'b0;
            stuck_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sync3_q    <= sync3_d;
            per_cnt_q  <= per_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            hi_cap_q   <= hi_cap_d;
            div_busy_q <= div_busy_d;
            it_q       <= it_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            div_hi_q   <= div_hi_d;
            div_per_q  <= div_per_d;
            high_q     <= high_d;
            period_q   <= period_d;
            duty_q     <= duty_d;
            valid_q    <= valid_d;
            stuck_q    <= stuck_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.high_cycles   = high_q;
    assign bus.period_cycles = period_q;
    assign bus.duty          = duty_q;
    assign bus.duty_valid    = valid_q;
    assign bus.stuck         = stuck_q;
    assign bus.overrun       = overrun_q;
    assign bus.dbg_state     = state_q;
endmodule

// File: tb/tb_pwm_duty_capture.sv
// Directed bench for pwm_duty_capture: known waveforms in, hand-computed captures expected.
module tb_pwm_duty_capture;
    localparam int CNT_W   = 16;
    localparam int DUTY_W  = 8;
    localparam int TIMEOUT = 4096;
    localparam int W       = 2 * CNT_W + DUTY_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    pwm_duty_capture_if #(.CNT_W(CNT_W), .DUTY_W(DUTY_W)) dif ();

    pwm_duty_capture #(.CNT_W(CNT_W), .DUTY_W(DUTY_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int           valid_t[$];
    int           ov_cnt = 0;
    int           n_chk  = 0;
    int           n_bad  = 0;
    logic [W-1:0] exp_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pack(input int hi, input int per, input int dt);
        return {CNT_W'(hi), CNT_W'(per), DUTY_W'(dt)};
    endfunction

    // monitor: every duty_valid strobe is matched against the next expected capture
    always @(negedge clk) begin
        if (dif.duty_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("extra_valid", 32'd1, 32'd0);
            end else begin
                exp_e = exp_q.pop_front();
                check("high",   32'(dif.high_cycles),   32'(exp_e[W-1 -: CNT_W]));
                check("period", 32'(dif.period_cycles), 32'(exp_e[DUTY_W +: CNT_W]));
                check("duty",   32'(dif.duty),          32'(exp_e[DUTY_W-1:0]));
            end
            valid_t.push_back(cyc);
        end
        if (dif.overrun === 1'b1) ov_cnt++;
    end

    // driver tasks
    task automatic drive(input logic v, input int n);
        dif.pwm_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic periods(input int p, input int h, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, h);
            drive(1'b0, p - h);
        end
    endtask

    task automatic do_reset();
        dif.pwm_in = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        valid_t.delete();
        ov_cnt = 0;
    endtask

    task automatic expect_n(input logic [W-1:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_high"},    32'(dif.high_cycles),   32'd0);
        check({tag, "_period"},  32'(dif.period_cycles), 32'd0);
        check({tag, "_duty"},    32'(dif.duty),          32'd0);
        check({tag, "_valid"},   32'(dif.duty_valid),    32'd0);
        check({tag, "_stuck"},   32'(dif.stuck),         32'd0);
        check({tag, "_overrun"}, 32'(dif.overrun),       32'd0);
    endtask

    initial begin
        dif.pwm_in = 1'b0;
        @(negedge clk);
        do_reset();
        check_all_zero("reset");

        // 1: period 256 / high 64, first rise only arms
        expect_n(pack(64, 256, 64), 4);
        periods(256, 64, 5);
        drive(1'b0, 20);
        check("t1_pending", 32'(exp_q.size()), 32'd0);
        check("t1_count", 32'(valid_t.size()), 32'd4);
        for (int i = 1; i < valid_t.size(); i++)
            check("t1_spacing", 32'(valid_t[i] - valid_t[i-1]), 32'd256);
        check("t1_overrun", 32'(ov_cnt), 32'd0);
        drive(1'b0, 50);
        check("t1_hold_duty", 32'(dif.duty), 32'd64);

        // 2: period 300 / high 100
        do_reset();
        expect_n(pack(100, 300, 85), 3);
        periods(300, 100, 4);
        drive(1'b0, 20);
        check("t2_pending", 32'(exp_q.size()), 32'd0);
        check("t2_overrun", 32'(ov_cnt), 32'd0);

        // 3: held high from reset, then recovery at period 256 / high 128
        do_reset();
        expect_n(pack(TIMEOUT, 0, 255), 1);
        drive(1'b1, TIMEOUT + 300);
        check("t3_pending", 32'(exp_q.size()), 32'd0);
        check("t3_stuck", 32'(dif.stuck), 32'd1);
        check("t3_count", 32'(valid_t.size()), 32'd1);
        drive(1'b0, 128);
        periods(256, 128, 1);
        check("t3_still_stuck", 32'(dif.stuck), 32'd1);
        expect_n(pack(128, 256, 128), 2);
        periods(256, 128, 2);
        drive(1'b0, 20);
        check("t3_recover_pending", 32'(exp_q.size()), 32'd0);
        check("t3_unstuck", 32'(dif.stuck), 32'd0);

        // 4: held low after a measurement
        expect_n(pack(0, 0, 0), 1);
        drive(1'b0, TIMEOUT + 100);
        check("t4_pending", 32'(exp_q.size()), 32'd0);
        check("t4_stuck", 32'(dif.stuck), 32'd1);
        check("t4_high", 32'(dif.high_cycles), 32'd0);

        // 5: period 6 / high 3 outruns the divider on every other rise
        do_reset();
        expect_n(pack(3, 6, 128), 4);
        periods(6, 3, 9);
        drive(1'b0, 20);
        check("t5_pending", 32'(exp_q.size()), 32'd0);
        check("t5_overrun", 32'(ov_cnt), 32'd4);

        // 6: reset in the middle of a division
        do_reset();
        expect_n(pack(64, 256, 64), 2);
        periods(256, 64, 3);
        check("t6_pre_pending", 32'(exp_q.size()), 32'd0);
        drive(1'b1, 6);
        rst = 1'b1;
        dif.pwm_in = 1'b0;
        @(negedge clk);
        check_all_zero("t6_rst");
        rst = 1'b0;
        drive(1'b0, 30);
        check("t6_no_valid", 32'(valid_t.size()), 32'd2);
        periods(256, 64, 1);
        check("t6_armed_only", 32'(valid_t.size()), 32'd2);
        expect_n(pack(64, 256, 64), 2);
        periods(256, 64, 2);
        drive(1'b0, 20);
        check("t6_pending", 32'(exp_q.size()), 32'd0);
        check("t6_count", 32'(valid_t.size()), 32'd4);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
